zbuf_port_sched: RTL and testbench

Arbiter and address sequencer for the single-port sample buffer that holds the 128 whitened sample vectors (z1..z4, 26 bits each) consumed by the FastICA engine. It arbitrates between three requesters: the input loader, which fills the buffer, the one-unit iteration pass, which needs a full sequential read per iteration, and the output demixing pass, which needs a full sequential read for y generation. It generates all RAM addresses and enables, and returns read data tagged with owner and last-sample markers. It sits between the top-level sequencer and the shared RAM macro, replacing the per-consumer private counters.

---
 rtl/zbuf_port_sched.sv | 155 +++++++++++++++
 tb/tb_zbuf_port_sched.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zbuf_port_sched.sv
// Sample-buffer port scheduler: fills the single-port z buffer, then
// arbitrates full sequential read passes between fast and out consumers.
module zbuf_port_sched #(
  parameter int DEPTH = 128,
  parameter int AW    = 7,
  parameter int DW    = 26
) (
  input  logic            clk_zsched,
  input  logic            rst_zsched,
  input  logic            ld_valid,
  input  logic [DW-1:0]   ld_z1,
  input  logic [DW-1:0]   ld_z2,
  input  logic [DW-1:0]   ld_z3,
  input  logic [DW-1:0]   ld_z4,
  output logic            ld_ready,
  input  logic            ld_clear,
  output logic            buf_full,
  input  logic            fast_req,
  input  logic            out_req,
  output logic            fast_done,
  output logic            out_done,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [4*DW-1:0] mem_wdata,
  input  logic [4*DW-1:0] mem_rdata,
  output logic            rd_valid,
  output logic            rd_owner,
  output logic            rd_last,
  output logic [DW-1:0]   rd_z1,
  output logic [DW-1:0]   rd_z2,
  output logic [DW-1:0]   rd_z3,
  output logic [DW-1:0]   rd_z4
);

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_READY = 2'd1;
  localparam logic [1:0] S_PASS  = 2'd2;

  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [1:0]  state;
  logic [AW:0] count;
  logic [AW:0] idx;
  logic        fast_pend;
  logic        out_pend;
  logic        clr_pend;
  logic        last_owner;
  logic        cur_owner;

  logic is_fill;
  logic is_ready;
  logic is_pass;
  logic acc;
  logic last_issue;
  logic clr;
  logic do_clr;
  logic grant_out;
  logic grant_fast;

  // Handshake, arbitration and RAM port drive
  always_comb begin
    is_fill    = (state == S_FILL);
    is_ready   = (state == S_READY);
    is_pass    = (state == S_PASS);
    ld_ready   = is_fill && (count < FULL);
    acc        = ld_valid && ld_ready;
    last_issue = is_pass && (idx == LAST);
    clr        = ld_clear || clr_pend;
    do_clr     = clr && (!is_pass || last_issue);
    grant_out  = out_pend && (!fast_pend || !last_owner);
    grant_fast = fast_pend && !grant_out;
    mem_en     = acc || is_pass;
    mem_we     = acc;
    mem_addr   = is_pass ? idx[AW-1:0] : count[AW-1:0];
    mem_wdata  = {ld_z1, ld_z2, ld_z3, ld_z4};
    rd_z1      = mem_rdata[4*DW-1:3*DW];
    rd_z2      = mem_rdata[3*DW-1:2*DW];
    rd_z3      = mem_rdata[2*DW-1:DW];
    rd_z4      = mem_rdata[DW-1:0];
    fast_done  = rd_valid && rd_last && !rd_owner;
    out_done   = rd_valid && rd_last && rd_owner;
  end

  // Fill counter, pending flags and FILL/READY/PASS sequencing
  always_ff @(posedge clk_zsched) begin
    if (rst_zsched) begin
      state      <= S_FILL;
      count      <= '0;
      idx        <= '0;
      fast_pend  <= 1'b0;
      out_pend   <= 1'b0;
      clr_pend   <= 1'b0;
      last_owner <= 1'b1;
      cur_owner  <= 1'b0;
      buf_full   <= 1'b0;
    end else if (do_clr) begin
      state      <= S_FILL;
      count      <= '0;
      idx        <= idx + 1'b1;
      fast_pend  <= 1'b0;
      out_pend   <= 1'b0;
      clr_pend   <= 1'b0;
      buf_full   <= 1'b0;
    end else begin
      fast_pend <= fast_pend || fast_req;
      out_pend  <= out_pend || out_req;
      clr_pend  <= clr_pend || ld_clear;
      case (state)
        S_FILL: begin
          if (acc) begin
            count <= count + 1'b1;
            if (count == LAST) begin
              buf_full <= 1'b1;
              state    <= S_READY;
            end
          end
        end
        S_READY: begin
          if (grant_fast || grant_out) begin
            state      <= S_PASS;
            idx        <= '0;
            cur_owner  <= grant_out;
            last_owner <= grant_out;
            if (grant_out) out_pend <= 1'b0;
            else fast_pend <= 1'b0;
          end
        end
        S_PASS: begin
          idx <= idx + 1'b1;
          if (last_issue) state <= S_READY;
        end
        default: state <= S_FILL;
      endcase
    end
  end

  // Read-return tag stage, one cycle behind the issued address
  always_ff @(posedge clk_zsched) begin
    if (rst_zsched) begin
      rd_valid <= 1'b0;
      rd_owner <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= is_pass;
      rd_owner <= is_pass && cur_owner;
      rd_last  <= last_issue;
    end
  end

  logic unused_ready;
  assign unused_ready = is_ready;

endmodule

// File: tb/tb_zbuf_port_sched.sv
// Directed bench for zbuf_port_sched with a behavioural single-port RAM.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_zbuf_port_sched;

  localparam int DEPTH = 128;
  localparam int AW    = 7;
  localparam int DW    = 26;

  logic            clk;
  logic            rst;
  logic            ld_valid;
  logic [DW-1:0]   ld_z1, ld_z2, ld_z3, ld_z4;
  logic            ld_ready;
  logic            ld_clear;
  logic            buf_full;
  logic            fast_req, out_req;
  logic            fast_done, out_done;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [4*DW-1:0] mem_wdata;
  logic [4*DW-1:0] mem_rdata;
  logic            rd_valid, rd_owner, rd_last;
  logic [DW-1:0]   rd_z1, rd_z2, rd_z3, rd_z4;

  logic [4*DW-1:0] ram [DEPTH];

  int n_cmp;
  int n_bad;

  zbuf_port_sched #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk_zsched(clk),
    .rst_zsched(rst),
    .ld_valid(ld_valid),
    .ld_z1(ld_z1),
    .ld_z2(ld_z2),
    .ld_z3(ld_z3),
    .ld_z4(ld_z4),
    .ld_ready(ld_ready),
    .ld_clear(ld_clear),
    .buf_full(buf_full),
    .fast_req(fast_req),
    .out_req(out_req),
    .fast_done(fast_done),
    .out_done(out_done),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .rd_valid(rd_valid),
    .rd_owner(rd_owner),
    .rd_last(rd_last),
    .rd_z1(rd_z1),
    .rd_z2(rd_z2),
    .rd_z3(rd_z3),
    .rd_z4(rd_z4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    ld_valid = 1'b0;
    ld_clear = 1'b0;
    fast_req = 1'b0;
    out_req = 1'b0;
    ld_z1 = '0; ld_z2 = '0; ld_z3 = '0; ld_z4 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (buf_full !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_buf_full got %b want 0", buf_full);
    end
    n_cmp++;
    if (ld_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ld_ready got %b want 1", ld_ready);
    end
    n_cmp++;
    if (rd_valid !== 1'b0 || rd_last !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_rd got %b%b want 00", rd_valid, rd_last);
    end
    n_cmp++;
    if (mem_en !== 1'b0 || fast_done !== 1'b0 || out_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle got en=%b fd=%b od=%b want 0",
               mem_en, fast_done, out_done);
    end
  endtask

  task automatic do_fill(input int req_at);
    logic [4*DW-1:0] exp_w;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      ld_valid = 1'b1;
      ld_z1 = DW'(i);
      ld_z2 = DW'(i + 200);
      ld_z3 = DW'(i * 3);
      ld_z4 = DW'(-i);
      out_req = (i == req_at);
      exp_w = {DW'(i), DW'(i + 200), DW'(i * 3), DW'(-i)};
      #1;
      n_cmp++;
      if (ld_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1) begin
        n_bad++;
        $display("FAIL fill_hs[%0d] got rdy=%b en=%b we=%b want 111",
                 i, ld_ready, mem_en, mem_we);
      end
      n_cmp++;
      if (mem_addr !== AW'(i)) begin
        n_bad++;
        $display("FAIL fill_addr got %0d want %0d", mem_addr, i);
      end
      n_cmp++;
      if (mem_wdata !== exp_w) begin
        n_bad++;
        $display("FAIL fill_wdata[%0d] got %h want %h", i, mem_wdata, exp_w);
      end
      n_cmp++;
      if (buf_full !== 1'b0) begin
        n_bad++;
        $display("FAIL fill_early_full[%0d] got %b want 0", i, buf_full);
      end
    end
    @(negedge clk);
    ld_valid = 1'b1;
    ld_z1 = DW'(999);
    out_req = 1'b0;
    #1;
    n_cmp++;
    if (buf_full !== 1'b1) begin
      n_bad++;
      $display("FAIL fill_full got %b want 1", buf_full);
    end
    n_cmp++;
    if (ld_ready !== 1'b0 || mem_en !== 1'b0) begin
      n_bad++;
      $display("FAIL fill_129th got rdy=%b en=%b want 00", ld_ready, mem_en);
    end
    ld_valid = 1'b0;
  endtask

  task automatic run_pass(input logic own, input int clr_k, input int rst_k);
    logic [DW-1:0] e1;
    logic [DW-1:0] e4;
    for (int k = 0; k <= DEPTH; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (k < DEPTH) begin
        n_cmp++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== AW'(k)) begin
          n_bad++;
          $display("FAIL pass_issue[%0d] got en=%b we=%b a=%0d want 1 0 %0d",
                   k, mem_en, mem_we, mem_addr, k);
        end
      end
      if (k == 0) begin
        n_cmp++;
        if (rd_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL pass_gap got rd_valid %b want 0", rd_valid);
        end
      end else begin
        e1 = DW'(k - 1);
        e4 = DW'(-(k - 1));
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_owner !== own) begin
          n_bad++;
          $display("FAIL pass_tag[%0d] got v=%b o=%b want 1 %b",
                   k - 1, rd_valid, rd_owner, own);
        end
        n_cmp++;
        if (rd_z1 !== e1 || rd_z4 !== e4) begin
          n_bad++;
          $display("FAIL pass_data[%0d] got %h %h want %h %h",
                   k - 1, rd_z1, rd_z4, e1, e4);
        end
        n_cmp++;
        if (rd_last !== (k == DEPTH) ||
            fast_done !== (k == DEPTH && !own) ||
            out_done !== (k == DEPTH && own)) begin
          n_bad++;
          $display("FAIL pass_last[%0d] got l=%b fd=%b od=%b", k - 1,
                   rd_last, fast_done, out_done);
        end
      end
      if (k == clr_k) begin
        ld_clear = 1'b1;
        out_req = 1'b1;
      end
      if (k == clr_k + 1) begin
        ld_clear = 1'b0;
        out_req = 1'b0;
      end
      if (k == rst_k) begin
        rst = 1'b1;
        return;
      end
    end
  endtask

  task automatic pulse_req(input logic f, input logic o);
    @(negedge clk);
    fast_req = f;
    out_req = o;
    @(negedge clk);
    fast_req = 1'b0;
    out_req = 1'b0;
    #1;
    n_cmp++;
    if (mem_en !== 1'b0 || rd_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL req_wait got en=%b v=%b want 00", mem_en, rd_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_fill();
    do_fill(-1);
  endtask

  task automatic test_contention();
    pulse_req(1'b1, 1'b1);
    run_pass(1'b0, -1, -1);
    @(negedge clk);
    run_pass(1'b1, -1, -1);
  endtask

  task automatic test_single_fast();
    pulse_req(1'b1, 1'b0);
    run_pass(1'b0, -1, -1);
  endtask

  task automatic test_round_robin();
    pulse_req(1'b1, 1'b1);
    run_pass(1'b1, -1, -1);
    @(negedge clk);
    run_pass(1'b0, -1, -1);
  endtask

  task automatic test_clear_mid_pass();
    int busy;
    pulse_req(1'b1, 1'b0);
    run_pass(1'b0, 50, -1);
    n_cmp++;
    if (buf_full !== 1'b0 || ld_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL clear_state got full=%b rdy=%b want 0 1",
               buf_full, ld_ready);
    end
    busy = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (mem_en !== 1'b0 || rd_valid !== 1'b0) busy++;
    end
    n_cmp++;
    if (busy !== 0) begin
      n_bad++;
      $display("FAIL clear_drop got %0d busy cycles want 0", busy);
    end
  endtask

  task automatic test_req_in_fill();
    do_fill(10);
    @(negedge clk);
    run_pass(1'b1, -1, -1);
  endtask

  task automatic test_reset_mid_pass();
    int bad;
    pulse_req(1'b1, 1'b0);
    run_pass(1'b0, -1, 60);
    @(negedge clk);
    #1;
    n_cmp++;
    if (rd_valid !== 1'b0 || fast_done !== 1'b0 || rd_last !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_pass_rd got v=%b fd=%b l=%b want 000",
               rd_valid, fast_done, rd_last);
    end
    n_cmp++;
    if (buf_full !== 1'b0 || ld_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_pass_state got full=%b rdy=%b want 0 1",
               buf_full, ld_ready);
    end
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      #1;
      if (rd_valid || fast_done || out_done || mem_en) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL rst_pass_quiet got %0d active cycles want 0", bad);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_fill();
    test_contention();
    test_single_fast();
    test_round_robin();
    test_clear_mid_pass();
    test_req_in_fill();
    test_reset_mid_pass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
